wb_config_store: RTL

- Wishbone slave that terminates the boot-time configuration writes issued by the housekeeping loader.
- Stores NUM_SOCLETS x NUM_ROWS 32-bit configuration words at byte address BASE_ADDR + soclet*64 + row*4.
- Tracks load completion and an address-error flag.
- Exposes a registered per-word readout port for the soclet configuration logic.

---
 rtl/wb_config_store.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_config_store.sv
// wb_config_store: Wishbone slave holding boot-time soclet config words with a registered readout port.
// Define CFG_READBACK_EN to let WB reads return stored data; otherwise WB reads return 0.
module wb_config_store #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter int          NUM_SOCLETS = 9,
  parameter int          NUM_ROWS    = 10,
  parameter int          ACK_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        cfg_rd_en,
  input  logic [3:0]  cfg_rd_soclet,
  input  logic [3:0]  cfg_rd_row,
  output logic [31:0] cfg_rd_data,
  output logic [7:0]  words_loaded,
  output logic        load_complete,
  output logic        addr_err
);
  localparam int TOTAL = NUM_SOCLETS * NUM_ROWS;
  localparam int IW    = $clog2(TOTAL);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t         state_q, state_d;
  logic [31:0]    adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d, rd_q, rd_d;
  logic           we_q, we_d, ack_q, ack_d, err_q, err_d, done_q, done_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     words_q, words_d;
  logic [31:0]    mem_q [TOTAL];
  logic [TOTAL-1:0] written_q;
  logic [31:0]    eff_adr, eff_dat, off;
  logic           eff_we, hit, commit, wr_en, rvalid;
  logic [IW-1:0]  idx, ridx;
  always_comb begin
    // With ACK_LATENCY==1 the commit edge is the capture edge, so decode the live bus in IDLE.
    eff_adr = state_q == IDLE ? wbs_adr_i : adr_q;
    eff_dat = state_q == IDLE ? wbs_dat_i : dat_q;
    eff_we  = state_q == IDLE ? wbs_we_i  : we_q;
    off     = eff_adr - BASE_ADDR;
    hit     = off < 32'(NUM_SOCLETS * 64) && off[1:0] == 2'b00 && {1'b0, off[5:2]} < 5'(NUM_ROWS);
    idx     = IW'(32'(off[9:6]) * NUM_ROWS + 32'(off[5:2]));
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    if (state_q == IDLE && wbs_cyc_i && wbs_stb_i) begin
      adr_d   = wbs_adr_i;
      dat_d   = wbs_dat_i;
      we_d    = wbs_we_i;
      cnt_d   = 3'(ACK_LATENCY - 1);
      state_d = ACK_LATENCY == 1 ? ACK : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - 3'd1;
      state_d = !wbs_cyc_i ? IDLE : cnt_q == 3'd1 ? ACK : WAIT;
    end else if (state_q == ACK) begin
      state_d = IDLE;
    end
    commit  = state_d == ACK;
    wr_en   = commit && hit && eff_we;
    ack_d   = commit;
`ifdef CFG_READBACK_EN
    rdat_d  = commit && hit && !eff_we ? mem_q[idx] : '0;
`else
    rdat_d  = '0;
`endif
    err_d   = err_q | (commit & ~hit);
    words_d = words_q + 8'(wr_en && !written_q[idx]);
    done_d  = words_d == 8'(TOTAL);
    rvalid  = {1'b0, cfg_rd_soclet} < 5'(NUM_SOCLETS) && {1'b0, cfg_rd_row} < 5'(NUM_ROWS);
    ridx    = IW'(32'(cfg_rd_soclet) * NUM_ROWS + 32'(cfg_rd_row));
    rd_d    = !cfg_rd_en ? rd_q : rvalid ? mem_q[ridx] : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      words_q   <= '0;
      written_q <= '0;
      for (int i = 0; i < TOTAL; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      done_q  <= done_d;
      words_q <= words_d;
      if (wr_en) begin
        mem_q[idx]     <= eff_dat;
        written_q[idx] <= 1'b1;
      end
    end
  end
  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = rdat_q;
  assign cfg_rd_data   = rd_q;
  assign words_loaded  = words_q;
  assign load_complete = done_q;
  assign addr_err      = err_q;
endmodule
